// File: rtl/apb_rr_xbar.sv
// ---------------------------------------------------------------------------------------------
// apb_rr_xbar: N-requester to M-completer APB crossbar with a single shared completer bus.
//
// One transfer is in flight at a time. Requesters are arbitrated round-robin in IDLE. The
// granted request is registered and replayed to the selected completer as a SETUP/ACCESS pair.
// The completer response is then returned to the owner for exactly one RESP cycle.
//
// Completer selection is PADDR >> REGION_BITS. A region index >= NUM_SLAVES is a decode miss.
// A miss selects no completer, spends a single ACCESS cycle and answers prdata=0, pslverr=1.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   m_psel/m_penable/m_pwrite      per-requester APB controls (NUM_MASTERS bits)
//   m_paddr, m_pwdata              per-requester address / write data, requester i in slice i
//   m_prdata/m_pready/m_pslverr    per-requester responses, only the owner sees non-zero values
//   s_psel                         one-hot completer select (NUM_SLAVES bits)
//   s_penable/s_pwrite/s_paddr/s_pwdata  shared completer bus
//   s_prdata/s_pready/s_pslverr    per-completer responses
//   grant_id                       index of the owning requester
//   busy                           high whenever the FSM is not in IDLE
//
// Build option
//   APB_XBAR_TIMEOUT_EN  when defined, ACCESS is abandoned after TIMEOUT_CYCLES cycles without
//                        pready. It then answers prdata=0, pslverr=1. When undefined, ACCESS
//                        waits indefinitely and no counter is built.
// ---------------------------------------------------------------------------------------------
module apb_rr_xbar #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned NUM_SLAVES     = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REGION_BITS    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  // requester side
  input  logic [NUM_MASTERS-1:0]            m_psel,
  input  logic [NUM_MASTERS-1:0]            m_penable,
  input  logic [NUM_MASTERS-1:0]            m_pwrite,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_paddr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_pwdata,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_prdata,
  output logic [NUM_MASTERS-1:0]            m_pready,
  output logic [NUM_MASTERS-1:0]            m_pslverr,
  // completer side
  output logic [NUM_SLAVES-1:0]             s_psel,
  output logic                              s_penable,
  output logic                              s_pwrite,
  output logic [ADDR_WIDTH-1:0]             s_paddr,
  output logic [DATA_WIDTH-1:0]             s_pwdata,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_prdata,
  input  logic [NUM_SLAVES-1:0]             s_pready,
  input  logic [NUM_SLAVES-1:0]             s_pslverr,
  // status
  output logic [$clog2(NUM_MASTERS)-1:0]    grant_id,
  output logic                              busy
);

  localparam int unsigned MW = $clog2(NUM_MASTERS);
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSetup  = 2'd1;
  localparam logic [1:0] StAccess = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  // The requester-side PENABLE carries no information this block needs.
  // Only PSEL marks a pending request.
  logic unused_penable;
  assign unused_penable = ^m_penable;

  // ---------------------------------------------------------------------------------------------
  // Unpack the flat buses into per-port arrays
  // ---------------------------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] maddr  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] mwdata [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] sdata  [NUM_SLAVES];

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_munpack
    assign maddr[i]  = m_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign mwdata[i] = m_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar j = 0; j < NUM_SLAVES; j++) begin : g_sunpack
    assign sdata[j] = s_prdata[j*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [MW-1:0]         last_q, last_d;    // most recent grant, round-robin pointer
  logic [MW-1:0]         grant_q, grant_d;  // current owner
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [SW-1:0]         sidx_q, sidx_d;
  logic                  miss_q, miss_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

`ifdef APB_XBAR_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // ---------------------------------------------------------------------------------------------
  // Round-robin pick: scan upward starting one past the previous owner.
  // ---------------------------------------------------------------------------------------------
  logic [MW-1:0] cand;
  logic [MW-1:0] pick;
  logic          pick_vld;

  always_comb begin
    cand     = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = MW'((32'(last_q) + k) % NUM_MASTERS);
      if (!pick_vld && m_psel[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // Decode the picked requester's address to a completer index.
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic [ADDR_WIDTH-1:0] pick_region;
  logic                  pick_miss;
  logic [SW-1:0]         pick_sidx;

  always_comb begin
    pick_addr   = maddr[pick];
    pick_region = pick_addr >> REGION_BITS;
    pick_miss   = (pick_region >= ADDR_WIDTH'(NUM_SLAVES));
    pick_sidx   = SW'(pick_region);
  end

  // Response of the selected completer; only meaningful when miss_q is low.
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    sel_ready = s_pready[sidx_q];
    sel_err   = s_pslverr[sidx_q];
    sel_data  = sdata[sidx_q];
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    sidx_d  = sidx_q;
    miss_d  = miss_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef APB_XBAR_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d = StSetup;
          last_d  = pick;
          grant_d = pick;
          addr_d  = pick_addr;
          wdata_d = mwdata[pick];
          write_d = m_pwrite[pick];
          sidx_d  = pick_sidx;
          miss_d  = pick_miss;
        end
      end

      StSetup: begin
        state_d = StAccess;
`ifdef APB_XBAR_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      StAccess: begin
        if (miss_q) begin
          // Nobody is selected, so answer the error ourselves after one cycle.
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else if (sel_ready) begin
          state_d = StResp;
          rdata_d = sel_data;
          err_d   = sel_err;
`ifdef APB_XBAR_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // This was the last permitted wait cycle. Abandon the completer.
          state_d = StResp;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      last_q  <= MW'(NUM_MASTERS - 1);  // requester 0 wins the first arbitration
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      sidx_q  <= '0;
      miss_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      sidx_q  <= sidx_d;
      miss_q  <= miss_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef APB_XBAR_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    s_psel    = '0;
    s_penable = 1'b0;
    if (!miss_q && (state_q == StSetup || state_q == StAccess)) begin
      s_psel[sidx_q] = 1'b1;
      s_penable      = (state_q == StAccess);
    end
    s_pwrite = write_q;
    s_paddr  = addr_q;
    s_pwdata = wdata_q;
  end

  // Only the owner sees a response, and only during RESP.
  always_comb begin
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = '0;
    if (state_q == StResp) begin
      m_pready[grant_q]                          = 1'b1;
      m_pslverr[grant_q]                         = err_q;
      m_prdata[grant_q*DATA_WIDTH +: DATA_WIDTH] = rdata_q;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_apb_rr_xbar.sv
// ---------------------------------------------------------------------------------------------
// tb_apb_rr_xbar: self-checking bench for apb_rr_xbar with default parameters.
// Directed scenarios followed by randomized single-transfer rounds, each checked against a
// transaction-level model. The model covers round-robin pick, region decode, expected latency,
// and expected response.
// ---------------------------------------------------------------------------------------------
module tb_apb_rr_xbar;

  localparam int NM = 4;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NM-1:0]     m_psel, m_penable, m_pwrite;
  logic [NM*AW-1:0]  m_paddr;
  logic [NM*DW-1:0]  m_pwdata;
  logic [NM*DW-1:0]  m_prdata;
  logic [NM-1:0]     m_pready, m_pslverr;
  logic [NS-1:0]     s_psel;
  logic              s_penable, s_pwrite;
  logic [AW-1:0]     s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic [NS*DW-1:0]  s_prdata;
  logic [NS-1:0]     s_pready, s_pslverr;
  logic [1:0]        grant_id;
  logic              busy;

  always #5 clk = ~clk;

  apb_rr_xbar #(
    .NUM_MASTERS   (NM),
    .NUM_SLAVES    (NS),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .REGION_BITS   (12),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_psel   (m_psel),
    .m_penable(m_penable),
    .m_pwrite (m_pwrite),
    .m_paddr  (m_paddr),
    .m_pwdata (m_pwdata),
    .m_prdata (m_prdata),
    .m_pready (m_pready),
    .m_pslverr(m_pslverr),
    .s_psel   (s_psel),
    .s_penable(s_penable),
    .s_pwrite (s_pwrite),
    .s_paddr  (s_paddr),
    .s_pwdata (s_pwdata),
    .s_prdata (s_prdata),
    .s_pready (s_pready),
    .s_pslverr(s_pslverr),
    .grant_id (grant_id),
    .busy     (busy)
  );

  // ---------------------------------------------------------------------------------------------
  // Completer model: a programmable number of wait states.
  // Read data is a fixed function of the completer index and address.
  // ---------------------------------------------------------------------------------------------
  int            wait_cfg    = 0;
  bit            never_ready = 1'b0;
  bit            override_en = 1'b0;
  logic [31:0]   override_val = '0;
  logic [NS-1:0] slverr_cfg  = '0;
  int            acc_cnt     = 0;

  function automatic logic [31:0] rd_fn(input int j, input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, 8'(j + 1), a[23:16]};
  endfunction

  always @(posedge clk) begin
    if (s_penable && (s_psel != '0)) acc_cnt <= acc_cnt + 1;
    else                             acc_cnt <= 0;
  end

  always_comb begin
    s_prdata  = '0;
    s_pready  = (!never_ready && acc_cnt >= wait_cfg) ? s_psel : '0;
    s_pslverr = slverr_cfg;
    for (int j = 0; j < NS; j++) begin
      s_prdata[j*DW +: DW] = override_en ? override_val : rd_fn(j, s_paddr);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Bookkeeping and helpers
  // ---------------------------------------------------------------------------------------------
  int          vectors     = 0;
  int          miscompares = 0;
  int          last_g      = NM - 1;  // model round-robin pointer
  logic [31:0] addr_v  [NM];
  logic [31:0] wdata_v [NM];
  logic [NM-1:0] write_v;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_masters(input logic [NM-1:0] mask);
    m_psel    = mask;
    m_penable = '0;
    m_pwrite  = write_v;
    for (int i = 0; i < NM; i++) begin
      m_paddr[i*AW +: AW]  = addr_v[i];
      m_pwdata[i*DW +: DW] = wdata_v[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_psel"},    128'(s_psel),    128'(0));
    check({tag, "_s_penable"}, 128'(s_penable), 128'(0));
    check({tag, "_s_pwrite"},  128'(s_pwrite),  128'(0));
    check({tag, "_s_paddr"},   128'(s_paddr),   128'(0));
    check({tag, "_s_pwdata"},  128'(s_pwdata),  128'(0));
    check({tag, "_m_pready"},  128'(m_pready),  128'(0));
    check({tag, "_m_prdata"},  128'(m_prdata),  128'(0));
    check({tag, "_m_pslverr"}, 128'(m_pslverr), 128'(0));
    check({tag, "_grant_id"},  128'(grant_id),  128'(0));
    check({tag, "_busy"},      128'(busy),      128'(0));
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m_psel = '0;
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    last_g = NM - 1;
  endtask

  // Applies one request pattern at a negedge in IDLE, follows the transfer to its RESP cycle,
  // and compares everything against the model's prediction.
  task automatic run_xfer(input logic [NM-1:0] mask, input int waits, input bit hold,
                          input bit drop_early, input bit expect_to, output int got_g);
    int            g, exp_lat, n;
    int unsigned   slave;
    bit            miss, got;
    logic [31:0]   a, exp_rd;
    logic          exp_err;
    logic [127:0]  exp_vec;
    logic [NS-1:0] exp_psel;

    wait_cfg = waits;
    drive_masters(mask);

    g = -1;
    for (int k = 1; k <= NM; k++) begin
      int c;
      c = (last_g + k) % NM;
      if (g < 0 && mask[c]) g = c;
    end

    a       = addr_v[g];
    slave   = a >> 12;
    miss    = (slave >= NS);
    exp_lat = miss ? 3 : (expect_to ? 2 + TO : 3 + waits);
    exp_rd  = (miss || expect_to) ? 32'h0 : (override_en ? override_val : rd_fn(int'(slave), a));
    exp_err = (miss || expect_to) ? 1'b1 : slverr_cfg[slave];
    exp_vec = '0;
    exp_vec[g*DW +: DW] = exp_rd;
    exp_psel = '0;
    if (!miss) exp_psel[slave] = 1'b1;

    got   = 1'b0;
    n     = 0;
    got_g = -1;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      check("psel_onehot0", 128'($onehot0(s_psel)), 128'(1));
      if (m_pready != '0) begin
        got   = 1'b1;
        got_g = int'(grant_id);
        check("latency",   128'(n),         128'(exp_lat));
        check("m_pready",  128'(m_pready),  128'(1) << g);
        check("m_prdata",  128'(m_prdata),  exp_vec);
        check("m_pslverr", 128'(m_pslverr), 128'(exp_err) << g);
        check("resp_psel", 128'(s_psel),    128'(0));
        check("resp_pen",  128'(s_penable), 128'(0));
        check("resp_gid",  128'(grant_id),  128'(g));
      end else begin
        check("busy",      128'(busy),      128'(1));
        check("grant_id",  128'(grant_id),  128'(g));
        check("s_psel",    128'(s_psel),    128'(exp_psel));
        check("s_penable", 128'(s_penable), 128'((n >= 2) && !miss));
        check("s_paddr",   128'(s_paddr),   128'(a));
        check("s_pwrite",  128'(s_pwrite),  128'(write_v[g]));
        check("s_pwdata",  128'(s_pwdata),  128'(wdata_v[g]));
        check("m_prdata_quiet",  128'(m_prdata),  128'(0));
        check("m_pslverr_quiet", 128'(m_pslverr), 128'(0));
      end
      if (drop_early && n == 1) m_psel = '0;
    end
    check("pready_seen", 128'(got), 128'(1));

    last_g = g;
    if (!hold) m_psel = '0;
    @(negedge clk);
    check("idle_busy",   128'(busy),     128'(0));
    check("idle_pready", 128'(m_pready), 128'(0));
  endtask

  // ---------------------------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------------------------
  int gg;
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    reset     = 1'b1;
    m_psel    = '0;
    m_penable = '0;
    m_pwrite  = '0;
    m_paddr   = '0;
    m_pwdata  = '0;
    write_v   = '0;
    for (int i = 0; i < NM; i++) begin
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Write from requester 1 to completer 1, zero wait
    addr_v[1]  = 32'h0000_1010;
    wdata_v[1] = 32'hDEAD_BEEF;
    write_v    = 4'b0010;
    slverr_cfg = '0;
    run_xfer(4'b0010, 0, 1'b0, 1'b0, 1'b0, gg);
    check("write_grant", 128'(gg), 128'(1));

    // Read with three wait states from completer 0
    addr_v[0]    = 32'h0000_0040;
    write_v      = '0;
    override_en  = 1'b1;
    override_val = 32'h1234_5678;
    run_xfer(4'b0001, 3, 1'b0, 1'b0, 1'b0, gg);
    override_en  = 1'b0;

    // Decode miss
    addr_v[2] = 32'h0000_5000;
    run_xfer(4'b0100, 0, 1'b0, 1'b0, 1'b0, gg);

    // Reset in the middle of ACCESS
    addr_v[3] = 32'h0000_0100;
    wait_cfg  = 5;
    drive_masters(4'b1000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("mid_access_pen",  128'(s_penable), 128'(1));
    check("mid_access_psel", 128'(s_psel),    128'(1));
    reset  = 1'b1;
    m_psel = '0;
    @(negedge clk);
    check_all_zero("midreset");
    reset  = 1'b0;
    last_g = NM - 1;
    @(negedge clk);
    check("post_reset_busy",   128'(busy),     128'(0));
    check("post_reset_pready", 128'(m_pready), 128'(0));

    // Round robin with all requesters holding PSEL
    for (int i = 0; i < NM; i++) addr_v[i] = 32'(i % 2) << 12 | 32'(i * 4);
    write_v = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      run_xfer(4'hF, 0, (k < 4), 1'b0, 1'b0, gg);
      check("rr_order", 128'(gg), 128'(rr_exp[k]));
    end

    // Completer that never answers
    addr_v[0]   = 32'h0000_0000;
    never_ready = 1'b1;
`ifdef APB_XBAR_TIMEOUT_EN
    run_xfer(4'b0001, 0, 1'b0, 1'b0, 1'b1, gg);
    never_ready = 1'b0;
`else
    drive_masters(4'b0001);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      check("hang_no_pready", 128'(m_pready), 128'(0));
    end
    check("hang_busy", 128'(busy),      128'(1));
    check("hang_pen",  128'(s_penable), 128'(1));
    check("hang_psel", 128'(s_psel),    128'(1));
    never_ready = 1'b0;
    do_reset();
    @(negedge clk);
`endif

    // Randomized rounds
    for (int r = 0; r < 60; r++) begin
      logic [NM-1:0] mask;
      for (int i = 0; i < NM; i++) begin
        int unsigned region;
        region     = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(2, 15))
                                                 : 32'($urandom_range(0, 1));
        addr_v[i]  = (region << 12) | ($urandom & 32'h0000_0FFC);
        wdata_v[i] = $urandom;
        write_v[i] = 1'($urandom_range(0, 1));
      end
      mask       = NM'($urandom_range(1, 15));
      slverr_cfg = NS'($urandom_range(0, 3));
      run_xfer(mask, int'($urandom_range(0, 3)), 1'b0, ($urandom_range(0, 3) == 0), 1'b0, gg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_rr_xbar.md
APB_RR_XBAR -- requirements
Module: apb_rr_xbar

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of APB requester ports (2..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 2, number of APB completer ports (1..8).
REQ-003 SHALL have parameters ADDR_WIDTH, default 32, and DATA_WIDTH, default 32, as the APB address and data widths.
REQ-004 SHALL have parameter REGION_BITS, default 12, where slave index = PADDR >> REGION_BITS.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16, the ACCESS-phase wait limit (see Configuration).
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 m_psel, m_penable, m_pwrite  input  NUM_MASTERS each  per-master APB controls.
REQ-009 m_paddr  input  NUM_MASTERS*ADDR_WIDTH; m_pwdata  input  NUM_MASTERS*DATA_WIDTH; master i occupies slice i.
REQ-010 m_prdata  output  NUM_MASTERS*DATA_WIDTH; m_pready, m_pslverr  output  NUM_MASTERS  per-master responses.
REQ-011 s_psel  output  NUM_SLAVES  one-hot completer select.
REQ-012 s_penable, s_pwrite  output  1; s_paddr  output  ADDR_WIDTH; s_pwdata  output  DATA_WIDTH; shared by all completers.
REQ-013 s_prdata  input  NUM_SLAVES*DATA_WIDTH; s_pready, s_pslverr  input  NUM_SLAVES  per-completer responses.
REQ-014 grant_id  output  clog2(NUM_MASTERS)  index of the owning master; busy  output  1  high in any state except IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
REQ-016 IDLE: when any m_psel is high, SHALL grant the first requester found scanning upward from (last_grant+1) modulo NUM_MASTERS, and SHALL register its addr, pwrite, pwdata and index, then enter SETUP.
REQ-017 last_grant SHALL update only on a grant; a master with m_psel low SHALL be skipped.
REQ-018 SETUP (1 cycle): s_psel[idx]=1, s_penable=0, with address, control and data driven from the registers.
REQ-019 ACCESS: s_psel[idx]=1, s_penable=1; the block SHALL stay in ACCESS until s_pready[idx]=1, then capture s_prdata[idx] and s_pslverr[idx] and enter RESP.
REQ-020 Decode miss (idx >= NUM_SLAVES): no s_psel bit SHALL assert in SETUP or ACCESS; ACCESS SHALL last 1 cycle and capture prdata=0, pslverr=1.
REQ-021 RESP (1 cycle): m_pready[grant]=1, m_prdata[grant] and m_pslverr[grant] SHALL be the captured values, and all s_psel bits SHALL be 0.
REQ-022 Non-granted masters SHALL see m_pready=0, m_pslverr=0 and m_prdata=0 at all times.
REQ-023 Latency: with a zero-wait completer, a request seen in IDLE at cycle t SHALL get m_pready at t+3; each completer wait state adds 1 cycle.
REQ-024 Masters dropping m_psel after grant SHALL NOT abort the transfer; the transfer completes to the completer.
REQ-025 At most one s_psel bit SHALL be high in any cycle; s_penable SHALL be 0 whenever all s_psel bits are 0.
REQ-026 A master holding m_psel high after RESP SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-027 On reset: state=IDLE; last_grant=NUM_MASTERS-1, so master 0 wins first; all captured registers=0.
REQ-028 On reset: all outputs SHALL be 0, including grant_id and busy.
REQ-029 Reset asserted mid-transfer SHALL return to IDLE on the next edge, drop s_psel and s_penable, and generate no m_pready.

Configuration
REQ-030 Macro APB_XBAR_TIMEOUT_EN defined: a counter SHALL clear on ACCESS entry; if s_pready[idx] stays 0 for TIMEOUT_CYCLES ACCESS cycles, the block SHALL drop s_psel and enter RESP with prdata=0, pslverr=1.
REQ-031 Macro APB_XBAR_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely; no counter logic is present.

Verification
REQ-032 Write: master 1 only, addr 0x0000_1010, data 0xDEAD_BEEF, zero-wait completer -> s_psel=2'b10 with s_paddr 0x1010; m_pready[1] at t+3, pslverr=0.
REQ-033 Round-robin: all 4 masters hold m_psel continuously -> grant order 0,1,2,3,0; no master is granted twice before the others.
REQ-034 Wait states: slave 0 holds pready low 3 cycles on a read returning 0x1234_5678 -> m_pready at t+6 with m_prdata=0x1234_5678.
REQ-035 Decode miss: addr 0x0000_5000 with NUM_SLAVES=2 -> no s_psel; m_pslverr=1, m_prdata=0 at t+3.
REQ-036 Reset mid-ACCESS -> next cycle state IDLE, all outputs 0; after release, master 0 wins first arbitration.
REQ-037 With APB_XBAR_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never ready -> m_pslverr=1 after 16 ACCESS cycles; without the macro, still waiting at cycle 100.
